// File: rtl/sobel_frame_engine.sv
// sobel_frame_engine
//   Streams one HxV frame out of the source BRAM in raster order and builds a
//   3x3 window from two line buffers, so each source pixel is read only once.
//   It computes the Sobel or Prewitt gradient magnitude |Gx|+|Gy|, saturated to
//   2^PIX_W-1, and writes one result per pixel to the destination BRAM. Border
//   pixels are written as 0.
//
//   Build option: define SOBEL_THRESHOLD_EN to binarise interior results.
//   An interior pixel becomes 2^PIX_W-1 when mag >= thr, otherwise 0. Without
//   the macro the saturated magnitude is written and thr is ignored.
//
// Ports
//   clk       clock, rising edge
//   rst_n     asynchronous reset, active HIGH (name kept from the old codebase)
//   start     1-cycle frame request, accepted only when idle
//   mode      0 = Sobel, 1 = Prewitt; captured when start is accepted
//   thr       binarisation threshold; captured when start is accepted
//   busy      high while a frame is being processed
//   done      1-cycle pulse, issued together with the last destination write
//   src_addr  source read address
//   src_rd    source read enable; src_data returns one cycle later
//   src_data  source read data
//   dst_addr  destination write address
//   dst_data  destination write data
//   dst_we    destination write enable
module sobel_frame_engine #(
  parameter int unsigned H      = 500,
  parameter int unsigned V      = 500,
  parameter int unsigned PIX_W  = 8,
  parameter int unsigned ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mode,
  input  logic [PIX_W-1:0]  thr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] src_addr,
  output logic              src_rd,
  input  logic [PIX_W-1:0]  src_data,
  output logic [ADDR_W-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data,
  output logic              dst_we
);

  localparam int unsigned N       = H * V;
  // Pixels pushed into the window per frame: N real pixels plus H+1 zeros
  // that drain the remaining centres.
  localparam int unsigned TOTAL   = N + H + 1;
  localparam int unsigned CNT_W   = $clog2(TOTAL + 1);
  localparam int unsigned COL_W   = $clog2(H);
  localparam int unsigned ROW_W   = $clog2(V);
  localparam int unsigned GW      = PIX_W + 3;
  localparam int unsigned MW      = PIX_W + 4;
  localparam int unsigned PIX_MAX = (1 << PIX_W) - 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t              r_state;
  state_t              w_nxt;
  logic                w_accept;
  logic                w_last_rd;
  logic                w_last_wr;

  logic                r_busy;
  logic                r_done;
  logic                r_src_rd;
  logic [ADDR_W-1:0]   r_src_addr;
  logic                r_dst_we;
  logic [ADDR_W-1:0]   r_dst_addr;
  logic [PIX_W-1:0]    r_dst_data;
  logic                r_mode;
  logic                r_vld_in;

  logic [CNT_W-1:0]    r_push_cnt;
  logic [COL_W-1:0]    r_push_col;
  logic [ROW_W-1:0]    r_k_row;
  logic [COL_W-1:0]    r_k_col;
  logic [ADDR_W-1:0]   r_k_addr;
  logic                r_win_vld;
  logic                r_win_border;
  logic [ADDR_W-1:0]   r_win_addr;

  logic                w_push;
  logic                w_centre;
  logic                w_border;
  logic [PIX_W-1:0]    w_px_in;

  logic [PIX_W-1:0]    r_lb0 [H];
  logic [PIX_W-1:0]    r_lb1 [H];
  logic [PIX_W-1:0]    r_w   [3][3];

  logic signed [GW-1:0] w_p [3][3];
  logic signed [GW-1:0] w_gx_t, w_gx_m, w_gx_b, w_gx;
  logic signed [GW-1:0] w_gy_l, w_gy_m, w_gy_r, w_gy;
  logic [GW-1:0]        w_ax, w_ay;
  logic [MW-1:0]        w_mag;
  logic [PIX_W-1:0]     w_sat;
  logic [PIX_W-1:0]     w_pix;

  assign busy     = r_busy;
  assign done     = r_done;
  assign src_rd   = r_src_rd;
  assign src_addr = r_src_addr;
  assign dst_we   = r_dst_we;
  assign dst_addr = r_dst_addr;
  assign dst_data = r_dst_data;

  assign w_accept  = (r_state == S_IDLE) && start;
  assign w_last_rd = (r_state == S_READ) && (r_src_addr == ADDR_W'(N - 1));
  assign w_last_wr = r_win_vld && (r_win_addr == ADDR_W'(N - 1));

  // Real pixels arrive one cycle after each read; afterwards zeros are fed in until every centre has been produced.
  assign w_push   = r_vld_in || ((r_state == S_FLUSH) && (r_push_cnt < CNT_W'(TOTAL)));
  assign w_px_in  = r_vld_in ? src_data : '0;
  // The centre trails the pushed pixel by H+1.
  assign w_centre = r_push_cnt >= CNT_W'(H + 1);
  assign w_border = (r_k_row == '0) || (r_k_row == ROW_W'(V - 1)) ||
                    (r_k_col == '0) || (r_k_col == COL_W'(H - 1));

  // State register
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_state <= S_IDLE;
    else       r_state <= w_nxt;
  end

  // Next-state logic
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start)     w_nxt = S_READ;
      S_READ:  if (w_last_rd) w_nxt = S_FLUSH;
      S_FLUSH: if (w_last_wr) w_nxt = S_DONE;
      S_DONE:                 w_nxt = S_IDLE;
      default:                w_nxt = S_IDLE;
    endcase
  end

  // Line buffers and window. They are never cleared because only border
  // centres can ever see stale contents.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_lb1[r_push_col] <= r_lb0[r_push_col];
      r_lb0[r_push_col] <= w_px_in;
      for (int i = 0; i < 3; i++) begin
        r_w[i][0] <= r_w[i][1];
        r_w[i][1] <= r_w[i][2];
      end
      r_w[0][2] <= r_lb1[r_push_col];
      r_w[1][2] <= r_lb0[r_push_col];
      r_w[2][2] <= w_px_in;
    end
  end

  // Gradient magnitude of the current window
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        w_p[i][j] = $signed(GW'(r_w[i][j]));
      end
    end
    w_gx_t = w_p[0][2] - w_p[0][0];
    w_gx_m = w_p[1][2] - w_p[1][0];
    w_gx_b = w_p[2][2] - w_p[2][0];
    w_gy_l = w_p[2][0] - w_p[0][0];
    w_gy_m = w_p[2][1] - w_p[0][1];
    w_gy_r = w_p[2][2] - w_p[0][2];
    w_gx   = w_gx_t + (r_mode ? w_gx_m : (w_gx_m <<< 1)) + w_gx_b;
    w_gy   = w_gy_l + (r_mode ? w_gy_m : (w_gy_m <<< 1)) + w_gy_r;
    w_ax   = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
    w_ay   = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
    w_mag  = MW'(w_ax) + MW'(w_ay);
    w_sat  = (w_mag > MW'(PIX_MAX)) ? PIX_W'(PIX_MAX) : w_mag[PIX_W-1:0];
  end

`ifdef SOBEL_THRESHOLD_EN
  logic [PIX_W-1:0] r_thr;
  assign w_pix = (w_sat >= r_thr) ? PIX_W'(PIX_MAX) : '0;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)         r_thr <= '0;
    else if (w_accept) r_thr <= thr;
  end
`else
  logic w_unused_thr;
  assign w_unused_thr = ^thr;
  assign w_pix        = w_sat;
`endif

  // Control, read address, centre tracking and output registers
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_src_rd     <= 1'b0;
      r_src_addr   <= '0;
      r_dst_we     <= 1'b0;
      r_dst_addr   <= '0;
      r_dst_data   <= '0;
      r_mode       <= 1'b0;
      r_vld_in     <= 1'b0;
      r_push_cnt   <= '0;
      r_push_col   <= '0;
      r_k_row      <= '0;
      r_k_col      <= '0;
      r_k_addr     <= '0;
      r_win_vld    <= 1'b0;
      r_win_border <= 1'b0;
      r_win_addr   <= '0;
    end else begin
      r_busy   <= (w_nxt == S_READ) || (w_nxt == S_FLUSH);
      r_done   <= (w_nxt == S_DONE);
      r_vld_in <= r_src_rd;

      if (r_state == S_READ) begin
        if (w_last_rd) r_src_rd   <= 1'b0;
        else           r_src_addr <= r_src_addr + ADDR_W'(1);
      end

      r_win_vld <= w_push && w_centre;
      if (w_push) begin
        r_push_cnt <= r_push_cnt + CNT_W'(1);
        r_push_col <= (r_push_col == COL_W'(H - 1)) ? '0 : r_push_col + COL_W'(1);
        if (w_centre) begin
          r_win_addr   <= r_k_addr;
          r_win_border <= w_border;
          r_k_addr     <= r_k_addr + ADDR_W'(1);
          if (r_k_col == COL_W'(H - 1)) begin
            r_k_col <= '0;
            r_k_row <= r_k_row + ROW_W'(1);
          end else begin
            r_k_col <= r_k_col + COL_W'(1);
          end
        end
      end

      if (w_accept) begin
        r_src_rd   <= 1'b1;
        r_src_addr <= '0;
        r_mode     <= mode;
        r_push_cnt <= '0;
        r_push_col <= '0;
        r_k_row    <= '0;
        r_k_col    <= '0;
        r_k_addr   <= '0;
      end

      r_dst_we <= r_win_vld;
      if (r_win_vld) begin
        r_dst_addr <= r_win_addr;
        r_dst_data <= r_win_border ? '0 : w_pix;
      end
    end
  end

endmodule

// File: tb/tb_sobel_frame_engine.sv
// Directed bench for sobel_frame_engine on an 8x8 frame. A matrix-form model
// computes the expected output image. One monitor compares every read address,
// write address and write data against that model. Hand-computed literals pin
// key pixels of each frame.
module tb_sobel_frame_engine;
  localparam int H  = 8;
  localparam int V  = 8;
  localparam int PW = 8;
  localparam int AW = 18;
  localparam int N  = H * V;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          mode;
  logic [PW-1:0] thr;
  logic          busy, done;
  logic [AW-1:0] src_addr, dst_addr;
  logic          src_rd, dst_we;
  logic [PW-1:0] src_data, dst_data;

  int            checks = 0;
  int            errors = 0;
  int            img     [N];
  logic [PW-1:0] exp_img [N];
  logic [PW-1:0] dst_mem [N];
  int            rd_cnt = 0, wr_cnt = 0, done_cnt = 0;
  int            rd_base = 0, wr_base = 0, dn_base = 0;

  always #5 clk = ~clk;

  sobel_frame_engine #(.H(H), .V(V), .PIX_W(PW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .thr(thr),
    .busy(busy), .done(done), .src_addr(src_addr), .src_rd(src_rd),
    .src_data(src_data), .dst_addr(dst_addr), .dst_data(dst_data), .dst_we(dst_we)
  );

  // Source BRAM with a one-cycle read
  always @(posedge clk) begin
    if (src_rd && (int'(src_addr) < N)) src_data <= PW'(img[src_addr]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic int at(input int r, input int c);
    return r * H + c;
  endfunction

  function automatic int px(input int r, input int c);
    return img[r * H + c];
  endfunction

  // Turns a hand-computed magnitude into the value the active build writes.
  function automatic int lit(input int mag, input int t);
`ifdef SOBEL_THRESHOLD_EN
    return (mag >= t) ? 255 : 0;
`else
    return (t >= 0) ? mag : mag;
`endif
  endfunction

  task automatic build_model(input logic m, input int t);
    int w, gx, gy, mag;
    w = m ? 1 : 2;
    for (int r = 0; r < V; r++) begin
      for (int c = 0; c < H; c++) begin
        if (r == 0 || r == V-1 || c == 0 || c == H-1) begin
          exp_img[at(r, c)] = '0;
        end else begin
          gx = (px(r-1,c+1) + w*px(r,c+1) + px(r+1,c+1)) - (px(r-1,c-1) + w*px(r,c-1) + px(r+1,c-1));
          gy = (px(r+1,c-1) + w*px(r+1,c) + px(r+1,c+1)) - (px(r-1,c-1) + w*px(r-1,c) + px(r-1,c+1));
          mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
          if (mag > 255) mag = 255;
`ifdef SOBEL_THRESHOLD_EN
          mag = (mag >= t) ? 255 : 0;
`endif
          exp_img[at(r, c)] = PW'(mag);
        end
      end
    end
  endtask

  // Checks every read and write against the model, and counts done pulses.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (src_rd) begin
        chk("src_addr", 32'(src_addr), 32'(rd_cnt - rd_base));
        rd_cnt++;
      end
      if (dst_we) begin
        chk("dst_addr", 32'(dst_addr), 32'(wr_cnt - wr_base));
        if ((wr_cnt - wr_base) < N) begin
          chk("dst_data", 32'(dst_data), 32'(exp_img[wr_cnt - wr_base]));
          dst_mem[wr_cnt - wr_base] = dst_data;
        end
        wr_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic run_frame(input logic m, input logic [PW-1:0] t);
    int cyc;
    bit got;
    build_model(m, int'(t));
    @(negedge clk);
    rd_base = rd_cnt; wr_base = wr_cnt; dn_base = done_cnt;
    mode = m; thr = t; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mode = ~m; thr = ~t;
    chk("busy_after_start", busy, 1);
    cyc = 1; got = 0;
    while (!got && cyc < N + H + 30) begin
      if (cyc == 10) start = 1'b1;
      if (cyc == 11) start = 1'b0;
      @(negedge clk);
      cyc++;
      if (done) got = 1;
    end
    chk("done_seen", got, 1);
    chk("done_latency_in_bound", (cyc - 1) <= (N + H + 8), 1);
    chk("busy_low_with_done", busy, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    repeat (4) @(negedge clk);
    chk("read_count", 32'(rd_cnt - rd_base), 32'(N));
    chk("write_count", 32'(wr_cnt - wr_base), 32'(N));
    chk("done_pulses", 32'(done_cnt - dn_base), 1);
  endtask

  task automatic load_step(input int lo, input int hi);
    for (int i = 0; i < N; i++) img[i] = ((i % H) < 4) ? lo : hi;
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; mode = 1'b0; thr = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_src_rd", src_rd, 0);
    chk("rst_dst_we", dst_we, 0);
    chk("rst_src_addr", 32'(src_addr), 0);
    chk("rst_dst_addr", 32'(dst_addr), 0);
    chk("rst_dst_data", 32'(dst_data), 0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Flat frame
    for (int i = 0; i < N; i++) img[i] = 8'h40;
    run_frame(1'b0, 8'd1);
    chk("flat_r0c0", 32'(dst_mem[at(0,0)]), 0);
    chk("flat_r3c3", 32'(dst_mem[at(3,3)]), 32'(lit(0, 1)));
    chk("flat_r7c7", 32'(dst_mem[at(7,7)]), 0);

    // Step 0 -> 20 in Sobel and Prewitt modes, then at two thresholds
    load_step(0, 20);
    run_frame(1'b0, 8'd1);
    chk("step_sob_r3c3", 32'(dst_mem[at(3,3)]), 32'(lit(80, 1)));
    chk("step_sob_r3c4", 32'(dst_mem[at(3,4)]), 32'(lit(80, 1)));
    chk("step_sob_r3c2", 32'(dst_mem[at(3,2)]), 32'(lit(0, 1)));
    chk("step_sob_r0c3", 32'(dst_mem[at(0,3)]), 0);
    chk("step_sob_r3c7", 32'(dst_mem[at(3,7)]), 0);
    run_frame(1'b1, 8'd1);
    chk("step_pre_r3c3", 32'(dst_mem[at(3,3)]), 32'(lit(60, 1)));
    chk("step_pre_r5c4", 32'(dst_mem[at(5,4)]), 32'(lit(60, 1)));
    run_frame(1'b0, 8'd50);
    chk("step_thr50_r2c4", 32'(dst_mem[at(2,4)]), 32'(lit(80, 50)));
    run_frame(1'b0, 8'd90);
    chk("step_thr90_r2c3", 32'(dst_mem[at(2,3)]), 32'(lit(80, 90)));

    // Single bright pixel at (3,3)
    for (int i = 0; i < N; i++) img[i] = 0;
    img[at(3,3)] = 100;
    run_frame(1'b0, 8'd1);
    chk("dot_r3c2", 32'(dst_mem[at(3,2)]), 32'(lit(200, 1)));
    chk("dot_r3c4", 32'(dst_mem[at(3,4)]), 32'(lit(200, 1)));
    chk("dot_r2c3", 32'(dst_mem[at(2,3)]), 32'(lit(200, 1)));
    chk("dot_r4c3", 32'(dst_mem[at(4,3)]), 32'(lit(200, 1)));
    chk("dot_r2c2", 32'(dst_mem[at(2,2)]), 32'(lit(200, 1)));
    chk("dot_r4c4", 32'(dst_mem[at(4,4)]), 32'(lit(200, 1)));
    chk("dot_r3c3", 32'(dst_mem[at(3,3)]), 32'(lit(0, 1)));

    // Saturation on a full-scale step
    load_step(0, 255);
    run_frame(1'b0, 8'd1);
    chk("sat_r3c3", 32'(dst_mem[at(3,3)]), 32'(lit(255, 1)));
    chk("sat_r6c4", 32'(dst_mem[at(6,4)]), 32'(lit(255, 1)));

    // Reset during READ, then confirm the engine stays quiet
    for (int i = 0; i < N; i++) img[i] = int'($urandom_range(0, 255));
    build_model(1'b0, 0);
    @(negedge clk);
    rd_base = rd_cnt; wr_base = wr_cnt;
    mode = 1'b0; thr = '0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    chk("midrst_reading", src_rd, 1);
    rst_n = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_src_rd", src_rd, 0);
    chk("midrst_dst_we", dst_we, 0);
    chk("midrst_src_addr", 32'(src_addr), 0);
    chk("midrst_dst_addr", 32'(dst_addr), 0);
    chk("midrst_dst_data", 32'(dst_data), 0);
    chk("midrst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b0;
    rd_base = rd_cnt; wr_base = wr_cnt;
    repeat (10) @(negedge clk);
    chk("midrst_no_reads", 32'(rd_cnt - rd_base), 0);
    chk("midrst_no_writes", 32'(wr_cnt - wr_base), 0);

    // Random frame after the reset, in both modes
    run_frame(1'b0, 8'd100);
    run_frame(1'b1, 8'd60);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
